rf_access_ctrl: RTL and testbench

- Initiator-side controller for the multicycle CPU's 32x32 register file.
- Accepts operand-read requests from the control unit and drives the RF's two read addresses.
- Captures RF read data, which the RF returns one clock after the address is sampled. Hands operands back to the control unit with a valid/ready handshake.
- Buffers writeback requests in a small queue, drains them into the RF write port, and forwards pending writes to reads.

---
 rtl/rf_access_ctrl_if.sv | 42 ++++
 rtl/rf_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_rf_access_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_access_ctrl_if.sv
// Bundle of the control-unit handshakes, the writeback request channel and the
// register-file ports seen by rf_access_ctrl. Clock and reset stay outside.
interface rf_access_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] rf_rr1;
    logic [AW-1:0] rf_rr2;
    logic [DW-1:0] rf_rd1;
    logic [DW-1:0] rf_rd2;
    logic [AW-1:0] rf_wr;
    logic [DW-1:0] rf_wd;
    logic          rf_w;
    logic          busy;

    // The controller is the slave of the control unit and drives the RF.
    modport slave (
        input  rd_req_valid, rd_addr_a, rd_addr_b, op_ready,
               wb_valid, wb_addr, wb_data, rf_rd1, rf_rd2,
        output rd_req_ready, op_valid, op_a, op_b, wb_ready,
               rf_rr1, rf_rr2, rf_wr, rf_wd, rf_w, busy
    );

    modport master (
        output rd_req_valid, rd_addr_a, rd_addr_b, op_ready,
               wb_valid, wb_addr, wb_data, rf_rd1, rf_rd2,
        input  rd_req_ready, op_valid, op_a, op_b, wb_ready,
               rf_rr1, rf_rr2, rf_wr, rf_wd, rf_w, busy
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// Register-file access controller: operand fetch FSM, writeback queue with drain
// and read bypass. Define RF_ZERO_REG_EN to make register 0 a hardwired zero.
module rf_access_ctrl #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int WBQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_access_ctrl_if.slave   bus
);
    localparam int PW = $clog2(WBQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rr1_q, rr1_d, rr2_q, rr2_d;
    logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic          op_valid_q, op_valid_d;

    logic [AW-1:0] wbq_addr_q [WBQ_DEPTH];
    logic [DW-1:0] wbq_data_q [WBQ_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          full, empty, push, push_en, pop;
    logic [PW-1:0] byp_idx;
    logic [DW-1:0] fwd_a, fwd_b;

    assign full  = (count_q == CW'(WBQ_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wb_valid && !full;
`ifdef RF_ZERO_REG_EN
    assign push_en = push && (bus.wb_addr != '0);
`else
    assign push_en = push;
`endif
    // Draining is withheld during ISSUE so the RF never reads and writes on one edge.
    assign pop = !empty && (state_q != ISSUE);

    assign bus.wb_ready     = !full;
    assign bus.rf_w         = pop;
    assign bus.rf_wr        = empty ? '0 : wbq_addr_q[rd_ptr_q];
    assign bus.rf_wd        = empty ? '0 : wbq_data_q[rd_ptr_q];
    assign bus.rd_req_ready = (state_q == IDLE);
    assign bus.rf_rr1       = rr1_q;
    assign bus.rf_rr2       = rr2_q;
    assign bus.op_valid     = op_valid_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.busy         = (state_q != IDLE) || !empty;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_a   = bus.rf_rd1;
        fwd_b   = bus.rf_rd2;
        byp_idx = '0;
        for (int i = 0; i < WBQ_DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                byp_idx = rd_ptr_q + PW'(i);
                if (wbq_addr_q[byp_idx] == rr1_q) fwd_a = wbq_data_q[byp_idx];
                if (wbq_addr_q[byp_idx] == rr2_q) fwd_b = wbq_data_q[byp_idx];
            end
        end
`ifdef RF_ZERO_REG_EN
        if (rr1_q == '0) fwd_a = '0;
        if (rr2_q == '0) fwd_b = '0;
`endif
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rr1_d      = rr1_q;
        rr2_d      = rr2_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rd_req_valid) begin
                    rr1_d   = bus.rd_addr_a;
                    rr2_d   = bus.rd_addr_b;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                op_a_d     = fwd_a;
                op_b_d     = fwd_b;
                op_valid_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr1_q      <= '0;
            rr2_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr1_q      <= rr1_d;
            rr2_q      <= rr2_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_en) - CW'(pop);
        end
    end

    // NOTE: queue storage has no reset; entries are only ever read below count_q.
    always_ff @(posedge clk) begin
        if (push_en) begin
            wbq_addr_q[wr_ptr_q] <= bus.wb_addr;
            wbq_data_q[wr_ptr_q] <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Randomized self-checking bench for rf_access_ctrl with a behavioural RF and a
// transaction-level reference model (architectural registers plus pending-write queue).
module tb_rf_access_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_access_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    rf_access_ctrl #(.DW(DW), .AW(AW), .WBQ_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural register file: registered read, write on rf_w, plus a preload port.
    logic [DW-1:0] rf_mem [32];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    always @(posedge clk) begin
        if (pl_we) rf_mem[pl_addr] <= pl_data;
        else if (bus.rf_w) rf_mem[bus.rf_wr] <= bus.rf_wd;
        bus.rf_rd1 <= rf_mem[bus.rf_rr1];
        bus.rf_rd2 <= rf_mem[bus.rf_rr2];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wb_t;
    wb_t           ref_q [$];
    logic [DW-1:0] ref_rf   [32];   // what the RF holds after drained writes
    logic [DW-1:0] ref_regs [32];   // architectural value: every accepted write applied
    int            phase;           // 0 idle, 1 issue, 2 capture, 3 hold
    logic [AW-1:0] fa, fb;
    logic [DW-1:0] exp_a, exp_b;

    typedef struct {
        bit            rv;
        bit [AW-1:0]   ra, rb;
        bit            wv;
        bit [AW-1:0]   wa;
        bit [DW-1:0]   wd;
        bit            ordy;
    } stim_t;

    stim_t directed [16] = '{
        '{1, 2, 3, 0, 0, 32'h0,        0},
        '{0, 0, 0, 1, 5, 32'hDEADBEEF, 0},
        '{0, 0, 0, 0, 0, 32'h0,        0},
        '{0, 0, 0, 0, 0, 32'h0,        1},
        '{1, 5, 6, 0, 0, 32'h0,        0},
        '{0, 0, 0, 0, 0, 32'h0,        0},
        '{0, 0, 0, 0, 0, 32'h0,        1},
        '{1, 7, 7, 1, 7, 32'h11,       0},
        '{0, 0, 0, 1, 7, 32'h22,       0},
        '{0, 0, 0, 1, 9, 32'h99,       0},
        '{0, 0, 0, 1, 0, 32'hFF,       1},
        '{1, 0, 7, 1, 4, 32'h44,       0},
        '{0, 0, 0, 1, 4, 32'h45,       0},
        '{0, 0, 0, 1, 4, 32'h46,       0},
        '{0, 0, 0, 0, 0, 32'h0,        1},
        '{0, 0, 0, 0, 0, 32'h0,        0}
    };

    function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] a);
        return (ZERO_EN && a == '0) ? '0 : ref_regs[a];
    endfunction

    task automatic check_outputs();
        bit exp_w;
        exp_w = (ref_q.size() > 0) && (phase != 1);
        check("rd_req_ready", bus.rd_req_ready, (phase == 0));
        check("wb_ready", bus.wb_ready, (ref_q.size() < DEPTH));
        check("rf_w", bus.rf_w, exp_w);
        if (exp_w) begin
            check("rf_wr", bus.rf_wr, ref_q[0].a);
            check("rf_wd", bus.rf_wd, ref_q[0].d);
        end
        if (phase == 1) begin
            check("rf_rr1", bus.rf_rr1, fa);
            check("rf_rr2", bus.rf_rr2, fb);
        end
        check("op_valid", bus.op_valid, (phase == 3));
        if (phase == 3) begin
            check("op_a", bus.op_a, exp_a);
            check("op_b", bus.op_b, exp_b);
        end
        check("busy", bus.busy, (phase != 0) || (ref_q.size() > 0));
    endtask

    task automatic drive_idle();
        bus.rd_req_valid = 1'b0;
        bus.rd_addr_a    = '0;
        bus.rd_addr_b    = '0;
        bus.op_ready     = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
    endtask

    task automatic drive(input stim_t s);
        bus.rd_req_valid = s.rv;
        bus.rd_addr_a    = s.ra;
        bus.rd_addr_b    = s.rb;
        bus.wb_valid     = s.wv;
        bus.wb_addr      = s.wa;
        bus.wb_data      = s.wd;
        bus.op_ready     = s.ordy;
    endtask

    // Advance the model across the coming posedge using the inputs just driven.
    task automatic step();
        bit  wb_acc, do_pop;
        wb_t e;
        do_pop = (ref_q.size() > 0) && (phase != 1);
        wb_acc = bus.wb_valid && (ref_q.size() < DEPTH);
        if (do_pop) begin
            e = ref_q.pop_front();
            ref_rf[e.a] = e.d;
        end
        if (wb_acc && !(ZERO_EN && bus.wb_addr == '0)) begin
            e.a = bus.wb_addr;
            e.d = bus.wb_data;
            ref_q.push_back(e);
            ref_regs[e.a] = e.d;
        end
        case (phase)
            0: if (bus.rd_req_valid) begin
                   fa = bus.rd_addr_a;
                   fb = bus.rd_addr_b;
                   phase = 1;
               end
            1: begin
                   exp_a = arch_val(fa);
                   exp_b = arch_val(fb);
                   phase = 2;
               end
            2: phase = 3;
            default: if (bus.op_ready) phase = 0;
        endcase
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_op_valid", bus.op_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rf_w", bus.rf_w, 1'b0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        phase = 0;
        ref_q.delete();
        for (int i = 0; i < 32; i++) ref_regs[i] = ref_rf[i];
        check("rst_op_a", bus.op_a, '0);
        check_outputs();
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        pl_we = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        phase = 0;
        fa = '0;
        fb = '0;
        exp_a = '0;
        exp_b = '0;
        drive_idle();

        // Preload the RF while the controller is held in reset.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = AW'(i);
            pl_data = (i == 2) ? 32'h123 : (i == 3) ? 32'h0 : $urandom;
            ref_rf[i]   = pl_data;
            ref_regs[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        check("reset_op_a", bus.op_a, '0);
        check("reset_op_b", bus.op_b, '0);
        check("reset_rf_rr1", bus.rf_rr1, '0);
        check("reset_rf_rr2", bus.rf_rr2, '0);
        check("reset_rf_wr", bus.rf_wr, '0);
        check("reset_rf_wd", bus.rf_wd, '0);
        check_outputs();
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            check_outputs();
            if (cyc > 40 && phase == 3 && ref_q.size() > 0 && $urandom_range(0, 7) == 0)
                pulse_reset();
            if (cyc < 16) begin
                s = directed[cyc];
            end else begin
                s.rv   = ($urandom_range(0, 2) != 0);
                s.ra   = AW'($urandom_range(0, 7));
                s.rb   = AW'($urandom_range(0, 7));
                s.wv   = ($urandom_range(0, 1) != 0);
                s.wa   = AW'($urandom_range(0, 7));
                s.wd   = $urandom;
                s.ordy = ($urandom_range(0, 2) == 0);
            end
            drive(s);
            step();
        end

        // Quiesce: release any held operands and let the queue drain.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_outputs();
            drive_idle();
            bus.op_ready = 1'b1;
            step();
        end
        @(negedge clk);
        check_outputs();
        for (int i = 0; i < 32; i++) check($sformatf("rf_final_r%0d", i), rf_mem[i], ref_regs[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
